// File: rtl/cond_pkg.sv
// Shared types for the NZCV condition evaluator: condition codes, FSM states
// and flag bit positions.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

endpackage

// File: rtl/cond_decode.sv
// Purely combinational condition-code check against an NZCV nibble.
// Shared with the execute unit so both agree on the decode table.
module cond_decode
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n;
   logic z;
   logic c;
   logic v;

   assign n = nzcv[N_BIT];
   assign z = nzcv[Z_BIT];
   assign c = nzcv[C_BIT];
   assign v = nzcv[V_BIT];

   always_comb begin
      pass = 1'b0;
      case (cond_e'(cond))
         EQ: pass = z;
         NE: pass = !z;
         CS: pass = c;
         CC: pass = !c;
         MI: pass = n;
         PL: pass = !n;
         VS: pass = v;
         VC: pass = !v;
         HI: pass = c & !z;
         LS: pass = !c | z;
         GE: pass = (n == v);
         LT: pass = (n != v);
         GT: pass = !z & (n == v);
         LE: pass = z | (n != v);
         AL: pass = 1'b1;
         NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_evaluator.sv
// Evaluates a conditional request against the architecturally current NZCV,
// snooping the flags write port to cover its two-cycle write-to-visible gap.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; evaluates immediately unless stalling
//   WAIT  | FORWARD=0 only: flag update in flight, wait for it to land
//   RESP  | result held on resp_* until the consumer takes it
module cond_evaluator
   import cond_pkg::*;
#(
   parameter int FORWARD = 1,
   parameter int TAG_W   = 4,
   parameter int CNT_W   = 16
)
(
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [3:0]       flags,
   input  logic [3:0]       NZCV,
   input  logic             CNTRL_update_en,
   input  logic             req_valid,
   input  logic [3:0]       req_cond,
   input  logic [TAG_W-1:0] req_tag,
   output logic             req_ready,
   output logic             resp_valid,
   output logic             resp_pass,
   output logic [TAG_W-1:0] resp_tag,
   input  logic             resp_ready,
   output logic [CNT_W-1:0] eval_count,
   output logic [CNT_W-1:0] stall_count
);

   state_e     state;
   state_e     state_nxt;
   logic       pipe0;
   logic [3:0] shadow;
   logic [3:0] cond_q;
   logic       pending;
   logic [3:0] eff_flags;
   logic [3:0] dec_cond;
   logic       dec_pass;
   logic       load_resp;
   logic       accept;

   assign pending = CNTRL_update_en | pipe0;

   // Newest in-flight write wins; the flags port is only trusted once both
   // pipeline slots are empty.
   always_comb begin
      eff_flags = flags;
      if (FORWARD != 0) begin
         if (CNTRL_update_en) begin
            eff_flags = NZCV;
         end else if (pipe0) begin
            eff_flags = shadow;
         end
      end
   end

   assign dec_cond = (state == IDLE) ? req_cond : cond_q;

   cond_decode u_decode (
      .cond (dec_cond),
      .nzcv (eff_flags),
      .pass (dec_pass)
   );

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid & req_ready;

   always_comb begin
      state_nxt = state;
      load_resp = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if ((FORWARD == 0) && pending) begin
                  state_nxt = WAIT;
               end else begin
                  state_nxt = RESP;
                  load_resp = 1'b1;
               end
            end
         end
         WAIT: begin
            if (!pending) begin
               state_nxt = RESP;
               load_resp = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         pipe0       <= 1'b0;
         shadow      <= 4'b0000;
         cond_q      <= 4'b0000;
         resp_pass   <= 1'b0;
         resp_tag    <= '0;
         eval_count  <= '0;
         stall_count <= '0;
      end else begin
         state <= state_nxt;
         pipe0 <= CNTRL_update_en;
         if (CNTRL_update_en) begin
            shadow <= NZCV;
         end
         if (accept) begin
            cond_q   <= req_cond;
            resp_tag <= req_tag;
         end
         if (load_resp) begin
            resp_pass <= dec_pass;
         end
         if ((state == WAIT) && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
         end
         if ((state == RESP) && resp_ready && (eval_count != {CNT_W{1'b1}})) begin
            eval_count <= eval_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cond_evaluator.sv
// Directed bench for cond_evaluator: one FORWARD=0 and one FORWARD=1 instance,
// each driven independently; the bench itself models the flags register.
module tb_cond_evaluator;

   localparam int TAG_W = 4;
   localparam int CNT_W = 16;

   typedef struct {
      logic [3:0] cond;
      logic [3:0] flg;
      logic       exp;
   } vec_t;

   logic             clk = 1'b0;
   logic [1:0]       rst_n;
   logic [3:0]       flags     [2];
   logic [3:0]       nzcv      [2];
   logic [1:0]       upd;
   logic [1:0]       req_valid;
   logic [3:0]       req_cond  [2];
   logic [TAG_W-1:0] req_tag   [2];
   logic [1:0]       resp_ready;

   wire [1:0]        req_ready;
   wire [1:0]        resp_valid;
   wire [1:0]        resp_pass;
   wire [TAG_W-1:0]  resp_tag    [2];
   wire [CNT_W-1:0]  eval_count  [2];
   wire [CNT_W-1:0]  stall_count [2];

   int checks = 0;
   int errors = 0;
   int exp_eval [2];
   vec_t vecs [20];

   always #10 clk = ~clk;

   cond_evaluator #(.FORWARD(0), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_f0 (
      .CLOCK_50        (clk),
      .RESET_N         (rst_n[0]),
      .flags           (flags[0]),
      .NZCV            (nzcv[0]),
      .CNTRL_update_en (upd[0]),
      .req_valid       (req_valid[0]),
      .req_cond        (req_cond[0]),
      .req_tag         (req_tag[0]),
      .req_ready       (req_ready[0]),
      .resp_valid      (resp_valid[0]),
      .resp_pass       (resp_pass[0]),
      .resp_tag        (resp_tag[0]),
      .resp_ready      (resp_ready[0]),
      .eval_count      (eval_count[0]),
      .stall_count     (stall_count[0])
   );

   cond_evaluator #(.FORWARD(1), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_f1 (
      .CLOCK_50        (clk),
      .RESET_N         (rst_n[1]),
      .flags           (flags[1]),
      .NZCV            (nzcv[1]),
      .CNTRL_update_en (upd[1]),
      .req_valid       (req_valid[1]),
      .req_cond        (req_cond[1]),
      .req_tag         (req_tag[1]),
      .req_ready       (req_ready[1]),
      .resp_valid      (resp_valid[1]),
      .resp_pass       (resp_pass[1]),
      .resp_tag        (resp_tag[1]),
      .resp_ready      (resp_ready[1]),
      .eval_count      (eval_count[1]),
      .stall_count     (stall_count[1])
   );

   // Reference written in the base-condition/invert form, not as a 16-way table.
   function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, b;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    b = z;
         3'd1:    b = cy;
         3'd2:    b = n;
         3'd3:    b = v;
         3'd4:    b = cy & ~z;
         3'd5:    b = ~(n ^ v);
         3'd6:    b = ~z & ~(n ^ v);
         default: b = 1'b1;
      endcase
      return c[0] ? ~b : b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input int d, input string nm);
      chk({nm, "_req_ready"},   32'(req_ready[d]),   32'd1);
      chk({nm, "_resp_valid"},  32'(resp_valid[d]),  32'd0);
      chk({nm, "_resp_pass"},   32'(resp_pass[d]),   32'd0);
      chk({nm, "_resp_tag"},    32'(resp_tag[d]),    32'd0);
      chk({nm, "_eval_count"},  32'(eval_count[d]),  32'd0);
      chk({nm, "_stall_count"}, 32'(stall_count[d]), 32'd0);
   endtask

   // Returns #1 after the edge on which the request was taken.
   task automatic accept_req(input int d, input logic [3:0] c, input logic [TAG_W-1:0] t);
      int n;
      req_valid[d] = 1'b1;
      req_cond[d]  = c;
      req_tag[d]   = t;
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
      step();
      req_valid[d] = 1'b0;
   endtask

   task automatic serve(input int d, input logic [3:0] c, input logic [3:0] f,
                        input logic [TAG_W-1:0] t, input logic e, input string nm);
      flags[d] = f;
      accept_req(d, c, t);
      chk({nm, "_valid"}, 32'(resp_valid[d]), 32'd1);
      chk({nm, "_pass"},  32'(resp_pass[d]),  32'(e));
      chk({nm, "_tag"},   32'(resp_tag[d]),   32'(t));
      step();
      exp_eval[d]++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{4'h0, 4'b0100, 1'b1};  vecs[1]  = '{4'h0, 4'b0000, 1'b0};
      vecs[2]  = '{4'h1, 4'b0100, 1'b0};  vecs[3]  = '{4'h2, 4'b0010, 1'b1};
      vecs[4]  = '{4'h3, 4'b0010, 1'b0};  vecs[5]  = '{4'h4, 4'b1000, 1'b1};
      vecs[6]  = '{4'h5, 4'b1000, 1'b0};  vecs[7]  = '{4'h6, 4'b0001, 1'b1};
      vecs[8]  = '{4'h7, 4'b0000, 1'b1};  vecs[9]  = '{4'h8, 4'b0010, 1'b1};
      vecs[10] = '{4'h8, 4'b0110, 1'b0};  vecs[11] = '{4'h9, 4'b0110, 1'b1};
      vecs[12] = '{4'hA, 4'b1001, 1'b1};  vecs[13] = '{4'hA, 4'b1000, 1'b0};
      vecs[14] = '{4'hB, 4'b1000, 1'b1};  vecs[15] = '{4'hC, 4'b0000, 1'b1};
      vecs[16] = '{4'hC, 4'b0100, 1'b0};  vecs[17] = '{4'hD, 4'b0100, 1'b1};
      vecs[18] = '{4'hE, 4'b0000, 1'b1};  vecs[19] = '{4'hF, 4'b1111, 1'b0};

      rst_n = 2'b00; upd = 2'b00; req_valid = 2'b00; resp_ready = 2'b11;
      for (int d = 0; d < 2; d++) begin
         flags[d] = 4'b0000; nzcv[d] = 4'b0000;
         req_cond[d] = 4'h0; req_tag[d] = '0; exp_eval[d] = 0;
      end
      #5;
      chk_reset(0, "rst_f0");
      chk_reset(1, "rst_f1");
      @(negedge clk);
      rst_n = 2'b11;
      step();

      // Basic EQ, latency of one cycle.
      flags[1] = 4'b0100;
      accept_req(1, 4'h0, 4'd3);
      chk("t1_valid", 32'(resp_valid[1]), 32'd1);
      chk("t1_pass",  32'(resp_pass[1]),  32'd1);
      chk("t1_tag",   32'(resp_tag[1]),   32'd3);
      step();
      exp_eval[1]++;
      chk("t1_eval", 32'(eval_count[1]), 32'd1);
      chk("t1_idle", 32'(resp_valid[1]), 32'd0);

      // Forward the in-flight NZCV on a same-cycle update.
      flags[1] = 4'b0000;
      upd[1] = 1'b1; nzcv[1] = 4'b1000;
      accept_req(1, 4'h4, 4'd1);
      upd[1] = 1'b0;
      chk("fwd_now_valid", 32'(resp_valid[1]), 32'd1);
      chk("fwd_now_pass",  32'(resp_pass[1]),  32'd1);
      step();
      exp_eval[1]++;
      flags[1] = 4'b1000;

      // Shadow used one cycle after the update while the port is still stale.
      flags[1] = 4'b0000;
      upd[1] = 1'b1; nzcv[1] = 4'b1000;
      step();
      upd[1] = 1'b0;
      accept_req(1, 4'h5, 4'd2);
      flags[1] = 4'b1000;
      chk("fwd_shadow_pass", 32'(resp_pass[1]), 32'd0);
      chk("fwd_shadow_tag",  32'(resp_tag[1]),  32'd2);
      step();
      exp_eval[1]++;

      // Hand-computed vectors on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 20; i++) begin
            serve(d, vecs[i].cond, vecs[i].flg, 4'(i), vecs[i].exp,
                  $sformatf("vec%0d_d%0d_c%0h_f%0h", i, d, vecs[i].cond, vecs[i].flg));
         end
      end

      // Full sweep with no updates.
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            serve(1, 4'(c), 4'(f), 4'(f), model_pass(4'(c), 4'(f)),
                  $sformatf("sweep_c%0h_f%0h", c, f));
         end
      end
      chk("sweep_eval", 32'(eval_count[1]), 32'(exp_eval[1]));
      chk("sweep_stall_f1", 32'(stall_count[1]), 32'd0);

      // FORWARD=0: same-cycle update stalls for two cycles.
      flags[0] = 4'b0000;
      upd[0] = 1'b1; nzcv[0] = 4'b0010;
      accept_req(0, 4'h2, 4'd5);
      upd[0] = 1'b0;
      chk("stall_t1_valid", 32'(resp_valid[0]), 32'd0);
      chk("stall_t1_ready", 32'(req_ready[0]),  32'd0);
      step();
      flags[0] = 4'b0010;
      chk("stall_t2_valid", 32'(resp_valid[0]), 32'd0);
      step();
      chk("stall_valid", 32'(resp_valid[0]),  32'd1);
      chk("stall_pass",  32'(resp_pass[0]),   32'd1);
      chk("stall_tag",   32'(resp_tag[0]),    32'd5);
      chk("stall_count", 32'(stall_count[0]), 32'd2);
      step();
      exp_eval[0]++;

      // FORWARD=0: a second update during WAIT extends the stall.
      upd[0] = 1'b1; nzcv[0] = 4'b0010;
      accept_req(0, 4'h3, 4'd6);
      nzcv[0] = 4'b0000;
      chk("ext_t1_valid", 32'(resp_valid[0]), 32'd0);
      step();
      upd[0] = 1'b0;
      flags[0] = 4'b0010;
      chk("ext_t2_valid", 32'(resp_valid[0]), 32'd0);
      step();
      flags[0] = 4'b0000;
      chk("ext_t3_valid", 32'(resp_valid[0]), 32'd0);
      step();
      chk("ext_valid", 32'(resp_valid[0]),  32'd1);
      chk("ext_pass",  32'(resp_pass[0]),   32'd1);
      chk("ext_tag",   32'(resp_tag[0]),    32'd6);
      chk("ext_stall", 32'(stall_count[0]), 32'd5);
      step();
      exp_eval[0]++;
      chk("f0_eval", 32'(eval_count[0]), 32'(exp_eval[0]));

      // Back-pressure: result held while flags and requests churn.
      flags[1] = 4'b0100;
      resp_ready[1] = 1'b0;
      accept_req(1, 4'h0, 4'd9);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d_valid", i), 32'(resp_valid[1]), 32'd1);
         chk($sformatf("hold%0d_pass", i),  32'(resp_pass[1]),  32'd1);
         chk($sformatf("hold%0d_tag", i),   32'(resp_tag[1]),   32'd9);
         chk($sformatf("hold%0d_ready", i), 32'(req_ready[1]),  32'd0);
         chk($sformatf("hold%0d_eval", i),  32'(eval_count[1]), 32'(exp_eval[1]));
         flags[1] = 4'(i);
         upd[1] = 1'b1; nzcv[1] = 4'b0000;
         req_valid[1] = 1'b1; req_tag[1] = 4'hF;
         step();
      end
      req_valid[1] = 1'b0; upd[1] = 1'b0;
      resp_ready[1] = 1'b1;
      chk("hold_end_tag", 32'(resp_tag[1]), 32'd9);
      step();
      exp_eval[1]++;
      chk("hold_eval", 32'(eval_count[1]), 32'(exp_eval[1]));
      chk("hold_idle", 32'(resp_valid[1]), 32'd0);

      // Reset while in WAIT.
      flags[0] = 4'b0000;
      upd[0] = 1'b1; nzcv[0] = 4'b1111;
      accept_req(0, 4'h0, 4'd7);
      upd[0] = 1'b0;
      chk("rw_in_wait", 32'(stall_count[0]), 32'd3 + 32'd5 - 32'd3 + 32'd0);
      #3 rst_n[0] = 1'b0;
      #1 chk_reset(0, "rst_wait");
      @(negedge clk);
      rst_n[0] = 1'b1;
      exp_eval[0] = 0;
      serve(0, 4'h0, 4'b0100, 4'd2, 1'b1, "post_rw");
      chk("post_rw_eval",  32'(eval_count[0]),  32'd1);
      chk("post_rw_stall", 32'(stall_count[0]), 32'd0);

      // Reset while holding a response.
      flags[1] = 4'b0100;
      resp_ready[1] = 1'b0;
      accept_req(1, 4'h0, 4'd8);
      chk("rr_in_resp", 32'(resp_valid[1]), 32'd1);
      #3 rst_n[1] = 1'b0;
      #1 chk_reset(1, "rst_resp");
      @(negedge clk);
      rst_n[1] = 1'b1;
      resp_ready[1] = 1'b1;
      exp_eval[1] = 0;
      serve(1, 4'h1, 4'b0000, 4'd4, 1'b1, "post_rr");
      chk("post_rr_eval", 32'(eval_count[1]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
